// File: rtl/dp_ram_interface_if.sv
// Peripheral register bus for dp_ram_interface.
// The master drives the strobes and write data. The slave returns the registered read data.
interface dp_ram_interface_if;
    logic        cs;
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [15:0] dat_in;
    logic [7:0]  dp_mem_addr;
    logic [15:0] dat_out;

    modport master (
        output cs,
        output wr,
        output rd,
        output addr,
        output dat_in,
        output dp_mem_addr,
        input  dat_out
    );

    modport slave (
        input  cs,
        input  wr,
        input  rd,
        input  addr,
        input  dat_in,
        input  dp_mem_addr,
        output dat_out
    );
endinterface

// File: rtl/dp_ram_interface.sv
// Register-mapped indirect access to an internal 256 x 16 dual-port RAM.
// Port A takes commit writes of DATA at ADDR. Port B feeds the RDWIN read window.
module dp_ram_interface (
    input  logic                  clk,
    input  logic                  rst,
    dp_ram_interface_if.slave     bus
);
    localparam logic [3:0] RegData   = 4'h0;
    localparam logic [3:0] RegRdwin  = 4'h2;
    localparam logic [3:0] RegAddr   = 4'h4;
    localparam logic [3:0] RegCommit = 4'h8;

    localparam int unsigned Depth = 256;

    logic [15:0] mem [Depth];

    logic [15:0] data_q, data_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] dat_out_q, dat_out_d;

    logic        wr_en;
    logic        rd_en;
    logic        commit_en;
    logic [15:0] rd_src;
    logic [15:0] port_b_rdata;

    // A write wins over a simultaneous read.
    assign wr_en     = bus.cs & bus.wr;
    assign rd_en     = bus.cs & bus.rd & ~bus.wr;
    assign commit_en = wr_en & (bus.addr == RegCommit) & ~rst;

    // Port A is the commit write port. RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (commit_en) begin
            mem[addr_q] <= data_q;
        end
    end

    // Port B is a combinational read, so that dat_out holds the pre-edge contents.
    assign port_b_rdata = mem[addr_q];

    always_comb begin
        data_d = data_q;
        addr_d = addr_q;
        if (wr_en) begin
            if (bus.addr == RegData) begin
                data_d = bus.dat_in;
            end
            if (bus.addr == RegAddr) begin
                addr_d = bus.dp_mem_addr;
            end
        end
    end

    always_comb begin
        rd_src = 16'h0000;
        case (bus.addr)
            RegData:  rd_src = data_q;
            RegRdwin: rd_src = port_b_rdata;
            RegAddr:  rd_src = {8'h00, addr_q};
            default:  rd_src = 16'h0000;
        endcase
    end

    always_comb begin
        dat_out_d = dat_out_q;
        if (rd_en) begin
            dat_out_d = rd_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= 16'h0000;
            addr_q    <= 8'h00;
            dat_out_q <= 16'h0000;
        end else begin
            data_q    <= data_d;
            addr_q    <= addr_d;
            dat_out_q <= dat_out_d;
        end
    end

    assign bus.dat_out = dat_out_q;
endmodule

// File: tb/tb_dp_ram_interface.sv
// Directed test bench for dp_ram_interface, with expected values computed by hand.
module tb_dp_ram_interface;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    dp_ram_interface_if bus ();

    dp_ram_interface dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.cs = 1'b0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    // Drives the strobes just after an edge, so that they are stable at the next edge.
    task automatic bus_write(input logic [3:0] a, input logic [15:0] d, input logic [7:0] ma,
                             input int cycles);
        bus.cs          = 1'b1;
        bus.wr          = 1'b1;
        bus.rd          = 1'b0;
        bus.addr        = a;
        bus.dat_in      = d;
        bus.dp_mem_addr = ma;
        repeat (cycles) @(posedge clk);
        #1;
        idle();
    endtask

    task automatic bus_read(input logic [3:0] a);
        bus.cs   = 1'b1;
        bus.wr   = 1'b0;
        bus.rd   = 1'b1;
        bus.addr = a;
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        bus.addr        = 4'h0;
        bus.dat_in      = 16'h0000;
        bus.dp_mem_addr = 8'h00;
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_dat_out", bus.dat_out, 16'h0000);
        bus_read(4'h0);
        check("reset_data", bus.dat_out, 16'h0000);
        bus_read(4'h4);
        check("reset_addr", bus.dat_out, 16'h0000);

        // Store 0x000B at 0x80, holding each strobe for 10 cycles.
        bus_write(4'h0, 16'h000B, 8'h00, 10);
        bus_write(4'h4, 16'hFFFF, 8'h80, 10);
        bus_write(4'h8, 16'hEEEE, 8'h00, 10);
        bus_write(4'h4, 16'h0000, 8'h80, 1);
        bus_read(4'h2);
        check("rdwin_0x80", bus.dat_out, 16'h000B);

        // Store 0x00FF at 0x55.
        bus_write(4'h0, 16'h00FF, 8'h00, 10);
        bus_write(4'h4, 16'h0000, 8'h55, 10);
        bus_write(4'h8, 16'h0000, 8'h00, 10);
        bus_write(4'h4, 16'h0000, 8'h55, 1);
        bus_read(4'h2);
        check("rdwin_0x55", bus.dat_out, 16'h00FF);
        bus_write(4'h4, 16'h0000, 8'h80, 1);
        bus_read(4'h2);
        check("rdwin_0x80_no_alias", bus.dat_out, 16'h000B);

        bus_read(4'h0);
        check("read_data", bus.dat_out, 16'h00FF);
        bus_write(4'h4, 16'h0000, 8'h55, 1);
        bus_read(4'h4);
        check("read_addr", bus.dat_out, 16'h0055);

        // rd is high but cs is low, so dat_out must hold.
        bus.cs   = 1'b0;
        bus.rd   = 1'b1;
        bus.addr = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        idle();
        check("idle_hold", bus.dat_out, 16'h0055);

        bus_read(4'h8);
        check("read_commit_zero", bus.dat_out, 16'h0000);

        // A write to an unmapped address must not change DATA or ADDR.
        bus_write(4'h6, 16'hABCD, 8'hAA, 1);
        bus_read(4'h0);
        check("unmapped_wr_data", bus.dat_out, 16'h00FF);
        bus_read(4'h4);
        check("unmapped_wr_addr", bus.dat_out, 16'h0055);
        bus_read(4'h6);
        check("unmapped_rd", bus.dat_out, 16'h0000);
        bus_read(4'h2);
        check("rdwin_after_unmapped", bus.dat_out, 16'h00FF);

        // cs, wr and rd all high: the write happens and dat_out holds.
        bus.cs     = 1'b1;
        bus.wr     = 1'b1;
        bus.rd     = 1'b1;
        bus.addr   = 4'h0;
        bus.dat_in = 16'h1234;
        @(posedge clk);
        #1;
        idle();
        check("wr_rd_hold", bus.dat_out, 16'h00FF);
        bus_read(4'h0);
        check("wr_rd_data", bus.dat_out, 16'h1234);

        // Back-to-back single-cycle commands: DATA, ADDR, COMMIT, then RDWIN.
        bus_write(4'h0, 16'h5A5A, 8'h00, 1);
        bus_write(4'h4, 16'h0000, 8'h10, 1);
        bus_write(4'h8, 16'h0000, 8'h00, 1);
        bus_read(4'h2);
        check("b2b_commit", bus.dat_out, 16'h5A5A);

        // A commit in the same cycle as a read of RDWIN is a write, so dat_out holds.
        bus_write(4'h0, 16'hC3C3, 8'h00, 1);
        bus.cs   = 1'b1;
        bus.wr   = 1'b1;
        bus.rd   = 1'b1;
        bus.addr = 4'h8;
        @(posedge clk);
        #1;
        idle();
        check("commit_rd_hold", bus.dat_out, 16'h5A5A);
        bus_read(4'h2);
        check("commit_rd_new", bus.dat_out, 16'hC3C3);

        // Reset in mid-operation. The write to DATA in the reset cycle is discarded.
        bus.cs     = 1'b1;
        bus.wr     = 1'b1;
        bus.addr   = 4'h0;
        bus.dat_in = 16'h7777;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        check("midrst_dat_out", bus.dat_out, 16'h0000);
        bus_read(4'h0);
        check("midrst_data", bus.dat_out, 16'h0000);
        bus_read(4'h4);
        check("midrst_addr", bus.dat_out, 16'h0000);
        bus_write(4'h4, 16'h0000, 8'h55, 1);
        bus_read(4'h2);
        check("midrst_ram_kept", bus.dat_out, 16'h00FF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
